// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// The slave side is the ALU; the master side is the issue stage and consumer.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_c;
    logic             out_z;
    logic             out_n;
    logic             out_v;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_c, out_z, out_n, out_v, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_c, out_z, out_n, out_v, out_err
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, sticky carry for ADC/SBB and an
// iterative shift-and-add multiplier taking WIDTH cycles.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  bus,
    output logic       busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_ADC = 4'd8;
    localparam logic [3:0] OP_SBB = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_SAR = 4'd11;

    logic [0:0]         state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d, err_q, err_d;
    logic               cf_q, cf_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mul_acc_q, mul_acc_d;
    logic [2*WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;

    logic [WIDTH-1:0]   a, b;
    logic [3:0]         op;
    logic [SHW-1:0]     amt;
    logic [WIDTH:0]     sum_ext, shl_ext, shr_ext, sar_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_err, cin;
    logic               op_is_mul, op_is_arith;
    logic               in_ready, accept, out_fire;
    logic [2*WIDTH-1:0] mul_acc_nx;

    assign a   = bus.in_a;
    assign b   = bus.in_b;
    assign op  = bus.in_op;
    assign amt = b[SHW-1:0];

    assign op_is_mul   = (op == OP_MUL) && (MUL_EN != 0);
    assign op_is_arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBB);

    // Shifts are done one bit wider so the last bit shifted out lands in a fixed
    // position; a zero shift amount then yields a carry of 0 automatically.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        sum_ext = '0;
        cin     = ((op == OP_ADC) || (op == OP_SBB)) ? cf_q : 1'b0;
        shl_ext = {1'b0, a} << amt;
        shr_ext = {a, 1'b0} >> amt;
        sar_ext = $signed({a, 1'b0}) >>> amt;
        case (op)
            OP_ADD, OP_ADC: begin
                sum_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                sum_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            OP_SAR: begin
                alu_res = sar_ext[WIDTH:1];
                alu_c   = sar_ext[0];
            end
            OP_CMP: begin
                alu_res[2] = a < b;
                alu_res[1] = a > b;
                alu_res[0] = a == b;
            end
            OP_MUL:  alu_err = (MUL_EN == 0);
            default: alu_err = 1'b1;
        endcase
    end

    assign mul_acc_nx = mul_b_q[0] ? (mul_acc_q + mul_a_q) : mul_acc_q;

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        c_d         = c_q;
        z_d         = z_q;
        n_d         = n_q;
        v_d         = v_q;
        err_d       = err_q;
        cf_d        = cf_q;
        cnt_d       = cnt_q;
        mul_acc_d   = mul_acc_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        case (state_q)
            ST_IDLE: begin
                if (out_fire)
                    out_valid_d = 1'b0;
                if (accept) begin
                    if (op_is_mul) begin
                        state_d   = ST_MUL;
                        mul_acc_d = '0;
                        mul_a_d   = {{WIDTH{1'b0}}, a};
                        mul_b_d   = b;
                        cnt_d     = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        c_d         = alu_c;
                        v_d         = alu_v;
                        err_d       = alu_err;
                        z_d         = (alu_res == '0);
                        n_d         = alu_res[WIDTH-1];
                        if (op_is_arith)
                            cf_d = alu_c;
                    end
                end
            end
            default: begin
                mul_acc_d = mul_acc_nx;
                mul_a_d   = mul_a_q << 1;
                mul_b_d   = mul_b_q >> 1;
                cnt_d     = cnt_q + CW'(1);
                // Final partial product is folded in on the same edge the result loads.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mul_acc_nx[WIDTH-1:0];
                    c_d         = |mul_acc_nx[2*WIDTH-1:WIDTH];
                    v_d         = 1'b0;
                    err_d       = 1'b0;
                    z_d         = (mul_acc_nx[WIDTH-1:0] == '0);
                    n_d         = mul_acc_nx[WIDTH-1];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
            cf_q        <= 1'b0;
            cnt_q       <= '0;
            mul_acc_q   <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            c_q         <= c_d;
            z_q         <= z_d;
            n_q         <= n_d;
            v_q         <= v_d;
            err_q       <= err_d;
            cf_q        <= cf_d;
            cnt_q       <= cnt_d;
            mul_acc_q   <= mul_acc_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_c      = c_q;
    assign bus.out_z      = z_q;
    assign bus.out_n      = n_q;
    assign bus.out_v      = v_q;
    assign bus.out_err    = err_q;
    assign busy           = (state_q == ST_MUL);
endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe (WIDTH=8, MUL_EN=1), scored against
// an integer-arithmetic reference model and an in-order result queue.
module tb_alu_pipe;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_bad = 0;
    int          mcf   = 0;
    logic [12:0] exp_q[$];
    logic [12:0] last_obs;
    logic        last_acc, last_fire;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Packed observation: {err, v, n, z, c, result}
    function automatic logic [12:0] pk(input int res, input int c, input int v, input int err);
        logic [7:0] r;
        r = res[7:0];
        return {err[0], v[0], r[7], (r == 8'h00), c[0], r};
    endfunction

    function automatic logic [12:0] model(input int op, input int a, input int b);
        int r, c, v, e, amt, sa, sb, s, ss, cin;
        r = 0; c = 0; v = 0; e = 0;
        amt = b % 8;
        sa  = (a >= 128) ? a - 256 : a;
        sb  = (b >= 128) ? b - 256 : b;
        cin = (op == 8 || op == 9) ? mcf : 0;
        case (op)
            0, 8: begin
                s  = a + b + cin;
                r  = s % 256;
                c  = (s > 255) ? 1 : 0;
                ss = sa + sb + cin;
                v  = (ss > 127 || ss < -128) ? 1 : 0;
            end
            1, 9: begin
                s  = a - b - cin;
                r  = (s + 512) % 256;
                c  = (s < 0) ? 1 : 0;
                ss = sa - sb - cin;
                v  = (ss > 127 || ss < -128) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                r = (a * (1 << amt)) % 256;
                c = (amt == 0) ? 0 : ((a >> (8 - amt)) & 1);
            end
            6: begin
                r = a >> amt;
                c = (amt == 0) ? 0 : ((a >> (amt - 1)) & 1);
            end
            11: begin
                r = (sa >>> amt) & 255;
                c = (amt == 0) ? 0 : ((a >> (amt - 1)) & 1);
            end
            7: r = ((a < b) ? 4 : 0) + ((a > b) ? 2 : 0) + ((a == b) ? 1 : 0);
            10: begin
                s = a * b;
                r = s % 256;
                c = (s > 255) ? 1 : 0;
            end
            default: begin
                e = 1;
                r = 0;
            end
        endcase
        if (op == 0 || op == 1 || op == 8 || op == 9)
            mcf = c;
        return pk(r, c, v, e);
    endfunction

    // Evaluate handshakes just before the next edge, then advance one cycle.
    task automatic step();
        logic [12:0] obs;
        #1;
        last_acc  = bus.in_valid && bus.in_ready;
        last_fire = bus.out_valid && bus.out_ready;
        if (bus.out_valid) begin
            obs = {bus.out_err, bus.out_v, bus.out_n, bus.out_z, bus.out_c, bus.out_result};
            if (exp_q.size() == 0)
                chk("spurious_valid", 32'(exp_q.size()), 32'd1);
            else
                chk("out", 32'(obs), 32'(exp_q[0]));
            if (last_fire) begin
                last_obs = obs;
                if (exp_q.size() > 0)
                    void'(exp_q.pop_front());
            end
        end
        if (last_acc)
            exp_q.push_back(model(32'(bus.in_op), 32'(bus.in_a), 32'(bus.in_b)));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.in_a     = 'x;
        bus.in_b     = 'x;
        bus.in_op    = 'x;
    endtask

    task automatic issue(input int op, input int a, input int b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = 4'(op);
        bus.in_a     = 8'(a);
        bus.in_b     = 8'(b);
        do begin
            step();
            n++;
        end while (!last_acc && n < 60);
        chk("issue_timeout", 32'(last_acc), 32'd1);
        idle_in();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic dop(input string tag, input int op, input int a, input int b, input logic [12:0] want);
        issue(op, a, b);
        drain();
        chk(tag, 32'(last_obs), 32'(want));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, bad_busy, hold_acc, na, nf;
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        idle_in();
        #12;
        chk("rst_state", 32'({bus.out_valid, busy, bus.out_result, bus.out_c, bus.out_z,
                              bus.out_n, bus.out_v, bus.out_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        dop("add_f0_20", 0, 8'hF0, 8'h20, pk(8'h10, 1, 0, 0));
        dop("adc_1_1",   8, 8'h01, 8'h01, pk(8'h03, 0, 0, 0));
        dop("add_7f_1",  0, 8'h7F, 8'h01, pk(8'h80, 0, 1, 0));
        dop("sub_3_5",   1, 8'h03, 8'h05, pk(8'hFE, 1, 0, 0));
        dop("sbb_5_3",   9, 8'h05, 8'h03, pk(8'h01, 0, 0, 0));
        dop("sub_80_1",  1, 8'h80, 8'h01, pk(8'h7F, 0, 1, 0));
        dop("cmp_5_3",   7, 8'h05, 8'h03, pk(8'h02, 0, 0, 0));
        dop("cmp_7_7",   7, 8'h07, 8'h07, pk(8'h01, 0, 0, 0));
        dop("shl_81_1",  5, 8'h81, 8'h01, pk(8'h02, 1, 0, 0));
        dop("shr_81_1",  6, 8'h81, 8'h01, pk(8'h40, 1, 0, 0));
        dop("sar_80_3", 11, 8'h80, 8'h03, pk(8'hF0, 0, 0, 0));
        dop("shl_81_9",  5, 8'h81, 8'h09, pk(8'h02, 1, 0, 0));
        dop("shl_81_0",  5, 8'h81, 8'h00, pk(8'h81, 0, 0, 0));

        // Multiply latency and busy window
        issue(10, 8'h0F, 8'h11);
        lat = 0;
        bad_busy = 0;
        while (!bus.out_valid && lat < 40) begin
            if (!busy || bus.in_ready)
                bad_busy++;
            step();
            lat++;
        end
        chk("mul_latency", 32'(lat), 32'd8);
        chk("mul_busy", 32'(bad_busy), 32'd0);
        drain();
        chk("mul_0f_11", 32'(last_obs), 32'(pk(8'hFF, 0, 0, 0)));
        dop("mul_10_10", 10, 8'h10, 8'h10, pk(8'h00, 1, 0, 0));

        // Backpressure with a second op waiting
        bus.out_ready = 1'b0;
        issue(0, 8'h12, 8'h34);
        bus.in_valid = 1'b1;
        bus.in_op    = 4'd4;
        bus.in_a     = 8'h0F;
        bus.in_b     = 8'hFF;
        hold_acc = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (last_acc)
                hold_acc++;
        end
        chk("bp_hold_accept", 32'(hold_acc), 32'd0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_same_edge", 32'({last_acc, last_fire}), 32'd3);
        idle_in();
        drain();

        // Full-throughput run
        na = 0;
        nf = 0;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = 4'd0;
            bus.in_a     = 8'($urandom_range(0, 255));
            bus.in_b     = 8'($urandom_range(0, 255));
            step();
            na += int'(last_acc);
            nf += int'(last_fire);
        end
        idle_in();
        step();
        nf += int'(last_fire);
        chk("b2b_accepts", 32'(na), 32'd16);
        chk("b2b_results", 32'(nf), 32'd16);
        drain();

        // Reset in the middle of a multiply, with cf set beforehand
        dop("add_ff_1", 0, 8'hFF, 8'h01, pk(8'h00, 1, 0, 0));
        issue(10, 8'h03, 8'h04);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mul", 32'({bus.out_valid, busy, bus.out_result, bus.out_c, bus.out_z,
                                bus.out_n, bus.out_v, bus.out_err}), 32'd0);
        exp_q.delete();
        mcf = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        dop("adc_after_rst", 8, 8'h01, 8'h01, pk(8'h02, 0, 0, 0));
        dop("illegal_c", 12, 8'h55, 8'hAA, pk(8'h00, 0, 0, 1));

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_op     = 4'($urandom_range(0, 15));
            bus.in_a      = 8'($urandom_range(0, 255));
            bus.in_b      = 8'($urandom_range(0, 255));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle_in();
        bus.out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
